fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the EX-stage 3:1 operand forwarding muxes (rs1 and rs2 paths) in the 5-stage pipelined core.
- Keeps its own shadow copy of the destination tags for the EX, MEM and WB stages.
- Detects load-use hazards and drives stall_o for PC/IF-ID hold and bubble insertion.
- Emits registered ForwardA/ForwardB select codes aligned with the instruction currently in EX.

Parameters:
- REG_ADDR_W, 5: register address width.
- CNT_W, 32: width of the stall performance counter (used only when the optional feature is enabled).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs1_i  in  REG_ADDR_W  ID source register 1.
- id_rs2_i  in  REG_ADDR_W  ID source register 2.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- id_rd_i  in  REG_ADDR_W  ID destination register.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the ID instruction (taken branch).
- mem_stall_i  in  1  data memory not ready; freeze the whole pipeline.
- stall_o  out  1  hold PC and IF/ID; insert a bubble into EX.
- ForwardA_o  out  2  select for the rs1 forwarding mux.
- ForwardB_o  out  2  select for the rs2 forwarding mux.
- ex_bubble_o  out  1  the EX stage holds a bubble.

Behaviour:
- Encoding: 00 = ID/EX register data; 10 = MEM ALU result; 01 = WB write data. Code 11 is never driven.
- Reset (async, rst_i=1):
  - All shadow tags and write-enables clear to 0.
  - ForwardA_o = ForwardB_o = 00; ex_bubble_o = 1.
  - stall_o goes to 0 combinationally.
- Shadow state: ex_rd, ex_rw, ex_mr; mem_rd, mem_rw; wb_rd, wb_rw.
- Load-use hazard (combinational) is true when all of:
  - id_valid_i and ex_mr and ex_rw;
  - ex_rd != 0;
  - (id_use_rs1_i and id_rs1_i == ex_rd) or (id_use_rs2_i and id_rs2_i == ex_rd).
- stall_o = mem_stall_i or (load-use hazard and not flush_i). Purely combinational, same-cycle.
- Advance happens on every clock edge where mem_stall_i = 0:
  - WB <- MEM and MEM <- EX.
  - EX <- ID fields when id_valid_i and not flush_i and no load-use hazard. Otherwise EX <- bubble (rw = mr = 0, ex_bubble_o = 1).
- Forward selects are computed at the advance edge for the instruction entering EX, and registered. Per source, evaluated against the pre-edge state:
  - src == ex_rd, ex_rw, ex_rd != 0: select 10.
  - else src == mem_rd, mem_rw, mem_rd != 0: select 01.
  - else: select 00.
  - Source not used, bubble, or x0: select 00.
- The nearest producer wins when EX and MEM both match.
- The WB-to-ID distance is covered by the register file's write-through. This block never forwards from the tag held in wb_rd. The wb_* tags are kept for debug/assertions only.
- Load followed by a dependent instruction costs exactly 1 stall cycle. After the bubble the load sits in MEM, and the consumer receives select 01.
- mem_stall_i = 1 freezes all state and outputs and forces stall_o = 1. It overrides flush_i and the hazard logic. Flush is applied on the first edge where mem_stall_i = 0, provided flush_i is still asserted.
- flush_i together with a load-use hazard: flush wins, stall_o = 0, bubble enters EX.
- Latency: selects are valid for the entire cycle the consumer spends in EX, from a flop output with no combinational path.

Optional Feature:
- Macro: FWD_HAZARD_STALL_CNT_EN.
- When defined:
  - Add output stall_cnt_o [CNT_W-1:0].
  - It increments on each non-frozen edge that inserts a load-use bubble. Flush bubbles are not counted.
  - It saturates at all-ones and clears on rst_i.
- When undefined: the port and the counter do not exist. Core behaviour is identical.

Decomposition:
- fwd_pkg holds:
  - localparams FWD_IDEX = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - REG_ADDR_W default;
  - shadow-stage struct typedef (rd, rw, mr).
- Sub-module fwd_sel:
  - Combinational priority comparator (src, use, ex tag, mem tag -> 2-bit select).
  - Instantiated twice, once for A and once for B.

Test Plan:
- Reset mid-run: assert rst_i asynchronously between edges -> ForwardA_o/ForwardB_o = 00, ex_bubble_o = 1, stall_o = 0 immediately.
- add x5 then sub x6,x5,x7 back-to-back -> stall_o = 0; ForwardA_o = 10 during sub's EX cycle. With one independent instruction between them -> ForwardA_o = 01.
- lw x5 then add x6,x0,x5 -> stall_o = 1 for exactly 1 cycle; a bubble enters EX; then ForwardB_o = 01 and ForwardA_o = 00.
- EX and MEM both write x8, consumer reads x8 on rs1 and rs2 -> ForwardA_o = ForwardB_o = 10. Writes to x0 -> selects stay 00.
- lw x5 in EX, dependent instruction in ID with flush_i = 1 -> stall_o = 0, bubble enters EX, no counter increment.
- mem_stall_i held 3 cycles during a lw-use hazard -> outputs frozen, stall_o = 1 throughout. After release exactly 1 hazard bubble is inserted, and stall_cnt_o = 1 when FWD_HAZARD_STALL_CNT_EN is defined.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared forwarding select codes, default tag width and the shadow-stage record
package fwd_pkg;
   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam int DEF_REG_ADDR_W = 5;
   typedef struct packed {
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic                      rw;
      logic                      mr;
   } stage_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: priority comparator picking the nearest producer of one EX source operand
module fwd_sel
   import fwd_pkg::*;
#(
   parameter int W = DEF_REG_ADDR_W
)(
   input  logic [W-1:0] i_src,
   input  logic         i_use,
   input  logic [W-1:0] i_ex_rd,
   input  logic         i_ex_rw,
   input  logic [W-1:0] i_mem_rd,
   input  logic         i_mem_rw,
   output logic [1:0]   o_sel
);
   // Unused sources and x0 never forward; the instruction one ahead beats the one two ahead
   always_comb
      o_sel = (!i_use || i_src == '0)            ? FWD_IDEX :
              (i_ex_rw && i_src == i_ex_rd)      ? FWD_MEM  :
              (i_mem_rw && i_src == i_mem_rd)    ? FWD_WB   : FWD_IDEX;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: load-use stall and registered EX forwarding selects for the 5-stage core
// Optional load-use stall counter output stall_cnt_o under `define FWD_HAZARD_STALL_CNT_EN
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef FWD_HAZARD_STALL_CNT_EN
   , parameter int CNT_W = 32
`endif
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   input  logic                  mem_stall_i,
   output logic                  stall_o,
   output logic [1:0]            ForwardA_o,
   output logic [1:0]            ForwardB_o,
   output logic                  ex_bubble_o
`ifdef FWD_HAZARD_STALL_CNT_EN
   , output logic [CNT_W-1:0]    stall_cnt_o
`endif
);
   stage_t     r_ex, r_mem, r_wb;
   logic [1:0] r_fa, r_fb;
   logic       r_bubble;
   logic       w_hazard, w_enter;
   logic [1:0] w_sel_a, w_sel_b;

   // A load in EX whose destination is read by the ID instruction must wait one cycle
   always_comb begin
      w_hazard = id_valid_i && r_ex.mr && r_ex.rw && r_ex.rd != '0 &&
                 ((id_use_rs1_i && id_rs1_i == r_ex.rd) || (id_use_rs2_i && id_rs2_i == r_ex.rd));
      w_enter  = id_valid_i && !flush_i && !w_hazard;
      stall_o  = mem_stall_i || (w_hazard && !flush_i);
   end

   fwd_sel #(.W(REG_ADDR_W)) u_sel_a (
      .i_src(id_rs1_i), .i_use(id_use_rs1_i),
      .i_ex_rd(r_ex.rd), .i_ex_rw(r_ex.rw),
      .i_mem_rd(r_mem.rd), .i_mem_rw(r_mem.rw),
      .o_sel(w_sel_a)
   );

   fwd_sel #(.W(REG_ADDR_W)) u_sel_b (
      .i_src(id_rs2_i), .i_use(id_use_rs2_i),
      .i_ex_rd(r_ex.rd), .i_ex_rw(r_ex.rw),
      .i_mem_rd(r_mem.rd), .i_mem_rw(r_mem.rw),
      .o_sel(w_sel_b)
   );

   // Advance the shadow pipeline and latch selects for the instruction entering EX
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_ex     <= '0;
         r_mem    <= '0;
         r_wb     <= '0;
         r_fa     <= FWD_IDEX;
         r_fb     <= FWD_IDEX;
         r_bubble <= 1'b1;
      end else if (!mem_stall_i) begin
         r_wb     <= r_mem;
         r_mem    <= r_ex;
         r_ex     <= w_enter ? stage_t'{rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i} : '0;
         r_fa     <= w_enter ? w_sel_a : FWD_IDEX;
         r_fb     <= w_enter ? w_sel_b : FWD_IDEX;
         r_bubble <= !w_enter;
      end

   assign ForwardA_o  = r_fa;
   assign ForwardB_o  = r_fb;
   assign ex_bubble_o = r_bubble;

   // A frozen pipeline keeps every shadow tag, including WB, and every select unchanged
   a_freeze: assert property (@(posedge clk_i) disable iff (rst_i)
      mem_stall_i |=> $stable({r_wb, r_mem, r_ex, r_fa, r_fb, r_bubble}));

`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Count load-use bubbles that actually enter EX; flush bubbles are excluded
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i)
         r_cnt <= '0;
      else if (!mem_stall_i && w_hazard && !flush_i && r_cnt != '1)
         r_cnt <= r_cnt + 1'b1;

   assign stall_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven bench with an expected-output queue for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       id_valid_i = 1'b0;
   logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
   logic       id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
   logic       id_regwrite_i = 1'b0, id_memread_i = 1'b0;
   logic       flush_i = 1'b0, mem_stall_i = 1'b0;
   logic       stall_o, ex_bubble_o;
   logic [1:0] ForwardA_o, ForwardB_o;
`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
`endif

   fwd_hazard_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .flush_i(flush_i), .mem_stall_i(mem_stall_i), .stall_o(stall_o),
      .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o), .ex_bubble_o(ex_bubble_o)
`ifdef FWD_HAZARD_STALL_CNT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       rw, mr, fl, ms;
      logic       es;
      logic [1:0] fa, fb;
      logic       bub;
   } vec_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       bub;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   row = 0;

   function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] rd, logic rw, logic mr, logic fl, logic ms,
                               logic es, logic [1:0] fa, logic [1:0] fb, logic bub);
      return '{v, rs1, rs2, u1, u2, rd, rw, mr, fl, ms, es, fa, fb, bub};
   endfunction

   function automatic vec_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, req);
   endtask

   task automatic drive(input vec_t t);
      id_valid_i = t.v; id_rs1_i = t.rs1; id_rs2_i = t.rs2;
      id_use_rs1_i = t.u1; id_use_rs2_i = t.u2; id_rd_i = t.rd;
      id_regwrite_i = t.rw; id_memread_i = t.mr; flush_i = t.fl; mem_stall_i = t.ms;
   endtask

   task automatic run_tbl();
      exp_t e;
      foreach (tbl[k]) begin
         @(negedge clk_i);
         drive(tbl[k]);
         #1 check("stall_o", row, 32'(stall_o), 32'(tbl[k].es));
         exp_q.push_back('{tbl[k].fa, tbl[k].fb, tbl[k].bub});
         @(posedge clk_i);
         #1 e = exp_q.pop_front();
         check("ForwardA_o", row, 32'(ForwardA_o), 32'(e.fa));
         check("ForwardB_o", row, 32'(ForwardB_o), 32'(e.fb));
         check("ex_bubble_o", row, 32'(ex_bubble_o), 32'(e.bub));
         row++;
      end
      tbl.delete();
   endtask

   task automatic check_cnt(input string nm, input int req);
`ifdef FWD_HAZARD_STALL_CNT_EN
      check(nm, row, stall_cnt_o, 32'(req));
`endif
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      #1 check("rst ForwardA_o", row, 32'(ForwardA_o), 0);
      check("rst ForwardB_o", row, 32'(ForwardB_o), 0);
      check("rst ex_bubble_o", row, 32'(ex_bubble_o), 1);
      check("rst stall_o", row, 32'(stall_o), 0);
      check_cnt("rst stall_cnt_o", 0);
      rst_i = 1'b0;
      // back-to-back ALU dependency, then with one independent instruction between
      tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0));
      tbl.push_back(idle());
      tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 3, 4, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0));
      tbl.push_back(idle());
      tbl.push_back(idle());
      // lw x5; add x6,x0,x5 : one stall, then WB select on rs2
      tbl.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 0, 5, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1));
      tbl.push_back(mk(1, 0, 5, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0));
      tbl.push_back(idle());
      tbl.push_back(idle());
      run_tbl();
      check_cnt("cnt after load-use", 1);
      // nearest producer wins, x0 never forwards, unused source ignored
      tbl.push_back(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0));
      tbl.push_back(mk(1, 3, 4, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 11, 11, 0, 1, 12, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
      tbl.push_back(idle());
      tbl.push_back(idle());
      // load to x0 followed by a reader of x0 is not a hazard
      tbl.push_back(mk(1, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      // flush beats load-use: no stall, bubble enters, not counted
      tbl.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 0, 0, 2'b00, 2'b00, 1));
      tbl.push_back(idle());
      tbl.push_back(idle());
      run_tbl();
      check_cnt("cnt after flush", 1);
      // memory stall freezes a pending load-use hazard for 3 cycles, flush ignored while frozen
      tbl.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 7, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b10, 2'b00, 0));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 1, 2'b10, 2'b00, 0));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 1, 1, 2'b10, 2'b00, 0));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 1, 2'b10, 2'b00, 0));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1));
      tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0));
      tbl.push_back(idle());
      tbl.push_back(idle());
      run_tbl();
      check_cnt("cnt after mem stall", 2);
      // asynchronous reset between edges while a hazard is pending
      tbl.push_back(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      tbl.push_back(mk(1, 7, 0, 1, 0, 5, 1, 1, 0, 0, 0, 2'b10, 2'b00, 0));
      run_tbl();
      @(negedge clk_i);
      drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      #1 check("pre-rst stall_o", row, 32'(stall_o), 1);
      #1 rst_i = 1'b1;
      #1 check("async rst stall_o", row, 32'(stall_o), 0);
      check("async rst ForwardA_o", row, 32'(ForwardA_o), 0);
      check("async rst ForwardB_o", row, 32'(ForwardB_o), 0);
      check("async rst ex_bubble_o", row, 32'(ex_bubble_o), 1);
      check_cnt("async rst stall_cnt_o", 0);
      row++;
      @(negedge clk_i);
      rst_i = 1'b0;
      tbl.push_back(idle());
      run_tbl();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
